// File: rtl/pipe_stage_skid.sv
// +--------------------------------------------------------------------------+
// | pipe_stage_skid: valid/ready pipeline register with one-entry skid,      |
// |   synchronous flush with bubble-PC injection. Rev 1.0                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module pipe_stage_skid #(
  parameter int               PAYLOAD_W = 256,
  parameter int               PC_W      = 32,
  parameter logic [PC_W-1:0]  RESET_PC  = 32'h00003000,
  parameter int               EXC_W     = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [PC_W-1:0]      flush_pc,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PC_W-1:0]      in_pc,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [EXC_W-1:0]     in_exc,
  input  logic                 in_bd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_W-1:0]      out_pc,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [EXC_W-1:0]     out_exc,
  output logic                 out_bd,
  output logic [1:0]           occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;

  logic                   r_in_ready;

  logic [PC_W-1:0]        r_main_pc;
  logic [PAYLOAD_W-1:0]   r_main_payload;
  logic [EXC_W-1:0]       r_main_exc;
  logic                   r_main_bd;

  logic [PC_W-1:0]        r_skid_pc;
  logic [PAYLOAD_W-1:0]   r_skid_payload;
  logic [EXC_W-1:0]       r_skid_exc;
  logic                   r_skid_bd;

  logic                   w_accept;
  logic                   w_pop;
  logic                   w_load_main_in;
  logic                   w_load_main_skid;
  logic                   w_load_skid;

  assign w_accept = in_valid & r_in_ready;
  assign w_pop    = out_valid & out_ready;

  always_comb begin
    w_next_state     = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    unique case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_load_main_in = 1'b1;
          w_next_state   = ONE;
        end
      end
      ONE: begin
        if (w_accept && !w_pop) begin
          w_load_skid  = 1'b1;
          w_next_state = TWO;
        end else if (w_accept && w_pop) begin
          w_load_main_in = 1'b1;
        end else if (w_pop) begin
          w_next_state = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so only a drain into main can happen
        if (w_pop) begin
          w_load_main_skid = 1'b1;
          w_next_state     = ONE;
        end
      end
      default: begin
        w_next_state = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= EMPTY;
      r_in_ready     <= 1'b1;
      r_main_pc      <= RESET_PC;
      r_main_payload <= '0;
      r_main_exc     <= '0;
      r_main_bd      <= 1'b0;
      r_skid_pc      <= '0;
      r_skid_payload <= '0;
      r_skid_exc     <= '0;
      r_skid_bd      <= 1'b0;
    end else if (flush) begin
      // Bubble keeps flush_pc so the exception unit still sees a valid EPC
      r_state        <= EMPTY;
      r_in_ready     <= 1'b1;
      r_main_pc      <= flush_pc;
      r_main_payload <= '0;
      r_main_exc     <= '0;
      r_main_bd      <= 1'b0;
      r_skid_pc      <= '0;
      r_skid_payload <= '0;
      r_skid_exc     <= '0;
      r_skid_bd      <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state != TWO);
      if (w_load_main_in) begin
        r_main_pc      <= in_pc;
        r_main_payload <= in_payload;
        r_main_exc     <= in_exc;
        r_main_bd      <= in_bd;
      end else if (w_load_main_skid) begin
        r_main_pc      <= r_skid_pc;
        r_main_payload <= r_skid_payload;
        r_main_exc     <= r_skid_exc;
        r_main_bd      <= r_skid_bd;
      end
      if (w_load_skid) begin
        r_skid_pc      <= in_pc;
        r_skid_payload <= in_payload;
        r_skid_exc     <= in_exc;
        r_skid_bd      <= in_bd;
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = (r_state != EMPTY);
  assign occupancy   = r_state;
  assign out_pc      = r_main_pc;
  assign out_payload = r_main_payload;
  assign out_exc     = r_main_exc;
  assign out_bd      = r_main_bd;

  // in_ready must always mirror "not full"
  a_ready_matches_state: assert property (@(posedge clk) disable iff (reset)
    r_in_ready == (r_state != TWO));

  a_state_legal: assert property (@(posedge clk) disable iff (reset)
    r_state != 2'd3);

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
// +--------------------------------------------------------------------------+
// | tb_pipe_stage_skid: scoreboard bench for pipe_stage_skid. Rev 1.0        |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pipe_stage_skid;

  localparam int              PAYLOAD_W = 256;
  localparam int              PC_W      = 32;
  localparam int              EXC_W     = 5;
  localparam logic [PC_W-1:0] RESET_PC  = 32'h00003000;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 flush;
  logic [PC_W-1:0]      flush_pc;
  logic                 in_valid;
  logic                 in_ready;
  logic [PC_W-1:0]      in_pc;
  logic [PAYLOAD_W-1:0] in_payload;
  logic [EXC_W-1:0]     in_exc;
  logic                 in_bd;
  logic                 out_valid;
  logic                 out_ready;
  logic [PC_W-1:0]      out_pc;
  logic [PAYLOAD_W-1:0] out_payload;
  logic [EXC_W-1:0]     out_exc;
  logic                 out_bd;
  logic [1:0]           occupancy;

  typedef struct packed {
    logic [PC_W-1:0]      pc;
    logic [PAYLOAD_W-1:0] payload;
    logic [EXC_W-1:0]     exc;
    logic                 bd;
  } beat_t;

  beat_t sb[$];
  int    vectors = 0;
  int    errors  = 0;

  pipe_stage_skid #(
    .PAYLOAD_W(PAYLOAD_W),
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC),
    .EXC_W    (EXC_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc      (in_pc),
    .in_payload (in_payload),
    .in_exc     (in_exc),
    .in_bd      (in_bd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_payload(out_payload),
    .out_exc    (out_exc),
    .out_bd     (out_bd),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  // Scoreboard: inputs change at posedge+1, so negedge sees this cycle's handshake
  always @(negedge clk) begin
    if (reset || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_pop: unexpected beat pc=%h, scoreboard empty", out_pc);
        end else begin
          beat_t exp_b;
          exp_b = sb.pop_front();
          if ({out_pc, out_payload, out_exc, out_bd} !== exp_b) begin
            errors++;
            $display("FAIL sb_beat: got pc=%h exc=%0d bd=%0b pl=%h, want pc=%h exc=%0d bd=%0b pl=%h",
                     out_pc, out_exc, out_bd, out_payload[31:0],
                     exp_b.pc, exp_b.exc, exp_b.bd, exp_b.payload[31:0]);
          end
        end
      end
      if (in_valid && in_ready)
        sb.push_back({in_pc, in_payload, in_exc, in_bd});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [PC_W-1:0] pc,
                       input logic [EXC_W-1:0] exc, input logic bd);
    in_valid   = v;
    in_pc      = pc;
    in_payload = {8{$urandom()}};
    in_exc     = exc;
    in_bd      = bd;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; flush_pc = '0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    tick(); tick();
    reset = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || out_pc !== RESET_PC || out_payload !== '0 ||
        in_ready !== 1'b1 || occupancy !== 2'd0 || out_exc !== '0 || out_bd !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got v=%b pc=%h rdy=%b occ=%0d exc=%0d bd=%b, want v=0 pc=%h rdy=1 occ=0 exc=0 bd=0",
               out_valid, out_pc, in_ready, occupancy, out_exc, out_bd, RESET_PC);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL reset_idle: got v=%b occ=%0d, want v=0 occ=0", out_valid, occupancy);
    end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      logic [PC_W-1:0] pc;
      pc = 32'h3000 + 32'(4 * i);
      drive(1'b1, pc, 5'd0, 1'b0);
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== pc || occupancy !== 2'd1) begin
        errors++;
        $display("FAIL stream_%0d: got v=%b pc=%h occ=%0d, want v=1 pc=%h occ=1",
                 i, out_valid, out_pc, occupancy, pc);
      end
    end
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    tick();
    vectors++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || sb.size() != 0) begin
      errors++;
      $display("FAIL stream_drain: got v=%b occ=%0d sb=%0d, want v=0 occ=0 sb=0",
               out_valid, occupancy, sb.size());
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 32'h3010, 5'd0, 1'b0); tick();
    drive(1'b1, 32'h3014, 5'd0, 1'b0); tick();
    vectors++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_pc !== 32'h3010 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL skid_full: got occ=%0d rdy=%b pc=%h v=%b, want occ=2 rdy=0 pc=00003010 v=1",
               occupancy, in_ready, out_pc, out_valid);
    end
    drive(1'b1, 32'h3018, 5'd0, 1'b0); tick();
    vectors++;
    if (occupancy !== 2'd2 || out_pc !== 32'h3010 || sb.size() != 2) begin
      errors++;
      $display("FAIL skid_block_c: got occ=%0d pc=%h sb=%0d, want occ=2 pc=00003010 sb=2",
               occupancy, out_pc, sb.size());
    end
    out_ready = 1'b1;
    tick();
    vectors++;
    if (out_pc !== 32'h3014 || in_ready !== 1'b1 || occupancy !== 2'd1) begin
      errors++;
      $display("FAIL skid_first_pop: got pc=%h rdy=%b occ=%0d, want pc=00003014 rdy=1 occ=1",
               out_pc, in_ready, occupancy);
    end
    tick();
    vectors++;
    if (out_pc !== 32'h3018 || occupancy !== 2'd1) begin
      errors++;
      $display("FAIL skid_c_out: got pc=%h occ=%0d, want pc=00003018 occ=1", out_pc, occupancy);
    end
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    tick();
    vectors++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL skid_drain: got v=%b sb=%0d, want v=0 sb=0", out_valid, sb.size());
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h3030, 5'd3, 1'b1); tick();
    drive(1'b1, 32'h3034, 5'd2, 1'b1); tick();
    flush = 1'b1; flush_pc = 32'h3020; out_ready = 1'b1;
    drive(1'b1, 32'h3038, 5'd1, 1'b1);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    vectors++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_pc !== 32'h3020 ||
        out_exc !== '0 || out_bd !== 1'b0 || in_ready !== 1'b1 || out_payload !== '0) begin
      errors++;
      $display("FAIL flush_two: got v=%b occ=%0d pc=%h exc=%0d bd=%b rdy=%b, want v=0 occ=0 pc=00003020 exc=0 bd=0 rdy=1",
               out_valid, occupancy, out_pc, out_exc, out_bd, in_ready);
    end
    // Flush from ONE while a beat is being accepted must drop it too
    drive(1'b1, 32'h303c, 5'd0, 1'b0); tick();
    flush = 1'b1; flush_pc = 32'h3024;
    drive(1'b1, 32'h3040, 5'd0, 1'b0);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    tick(); tick();
    vectors++;
    if (out_valid !== 1'b0 || out_pc !== 32'h3024 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL flush_one_accept: got v=%b pc=%h occ=%0d, want v=0 pc=00003024 occ=0",
               out_valid, out_pc, occupancy);
    end
  endtask

  task automatic test_sideband();
    out_ready = 1'b0;
    drive(1'b1, 32'h3040, 5'd4, 1'b1); tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0); tick();
    out_ready = 1'b1;
    vectors++;
    if (out_valid !== 1'b1 || out_exc !== 5'd4 || out_bd !== 1'b1 || out_pc !== 32'h3040) begin
      errors++;
      $display("FAIL sideband: got v=%b exc=%0d bd=%b pc=%h, want v=1 exc=4 bd=1 pc=00003040",
               out_valid, out_exc, out_bd, out_pc);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0 || out_pc !== 32'h3040) begin
      errors++;
      $display("FAIL sideband_pop: got v=%b pc=%h, want v=0 pc=00003040 held", out_valid, out_pc);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    out_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 1) == 1, 32'h4000 + 32'(4 * i),
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      tick();
    end
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    out_ready = 1'b1;
    while (out_valid === 1'b1 && n < 8) begin
      tick();
      n++;
    end
    vectors++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: got v=%b sb=%0d, want v=0 sb=0", out_valid, sb.size());
    end
  endtask

  task automatic test_reset_vs_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h3050, 5'd7, 1'b1); tick();
    drive(1'b1, 32'h3054, 5'd7, 1'b1); tick();
    reset = 1'b1; flush = 1'b1; flush_pc = 32'h3020;
    tick();
    reset = 1'b0; flush = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    vectors++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_pc !== RESET_PC || in_ready !== 1'b1 ||
        out_payload !== '0 || out_exc !== '0 || out_bd !== 1'b0) begin
      errors++;
      $display("FAIL reset_over_flush: got v=%b occ=%0d pc=%h rdy=%b exc=%0d bd=%b, want v=0 occ=0 pc=%h rdy=1 exc=0 bd=0",
               out_valid, occupancy, out_pc, in_ready, out_exc, out_bd, RESET_PC);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_sideband();
    test_back_to_back();
    test_reset_vs_flush();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
